// File: rtl/tbuart_pkg.sv
// tbuart_pkg: shared definitions for the test-bench UART.
//   uart_state_e         - common TX/RX state encoding
//   DATA_BITS, STOP_BITS - 8N1 frame shape
//   CLKS_PER_BIT_DEFAULT - 115200 baud at 40 MHz
`timescale 1ns/1ps
package tbuart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;
  localparam int CLKS_PER_BIT_DEFAULT = 347;

endpackage

// File: rtl/tbuart_rx.sv
// tbuart_rx: 8N1 serial receiver.
//   clock, resetb - system clock, asynchronous active-low reset
//   ser_rx        - asynchronous serial input, idle high
//   rx_done       - one-cycle pulse: a byte with a valid stop bit arrived
//   rx_byte       - last good byte, valid from rx_done onwards
//   rx_ferr       - one-cycle pulse: stop bit sampled low, byte discarded
`timescale 1ns/1ps
module tbuart_rx
  import tbuart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic                 ser_rx,
  output logic                 rx_done,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_ferr
);

  localparam int                CW        = $clog2(CLKS_PER_BIT + 1);
  localparam int                IW        = $clog2(DATA_BITS);
  localparam logic [CW-1:0]     BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]     HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, prev_q;
  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;     // waiting for the line to go high after a framing error
  logic                 rx_in, rx_fall;

  // The synchronizer resets low, so a line that is already high after reset
  // never looks like a falling edge: prev_q follows sync2_q up to 1 first.
  assign rx_in   = sync2_q;
  assign rx_fall = prev_q & ~sync2_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    byte_d  = byte_q;
    brk_d   = brk_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (rx_fall) state_d = ST_START;
      end

      ST_START: begin
        // Half a bit in: a line that is high again was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_in ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_in, shreg_q[DATA_BITS-1:1]};   // LSB arrives first
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_STOP: begin
        if (brk_q) begin
          if (rx_in) begin
            brk_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_in) begin
            byte_d  = shreg_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d = 1'b1;
            brk_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        brk_d   = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      sync1_q <= ser_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
    end
  end

  assign rx_done = done_q;
  assign rx_byte = byte_q;
  assign rx_ferr = ferr_q;

endmodule

// File: rtl/tbuart.sv
// tbuart: test-bench UART, full duplex 8N1.
//   clock, resetb - system clock, asynchronous active-low reset
//   ser_rx        - serial data from the chip UART TX (idle high)
//   tx_start      - level request; a rising edge starts one frame of tx_data
//   tx_data       - byte to transmit, latched when a frame starts
//   ser_tx        - serial data to the chip UART RX (idle high)
//   tx_busy       - high while a TX frame is in progress
//   tx_clear_req  - set on each good received byte, cleared on each TX start
`timescale 1ns/1ps
module tbuart
  import tbuart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic                 ser_rx,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 ser_tx,
  output logic                 tx_busy,
  output logic                 tx_clear_req
);

  localparam int            CW        = $clog2(CLKS_PER_BIT * STOP_BITS + 1);
  localparam int            IW        = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  // ---------------- receiver ----------------
  logic                 rx_done;
  logic [DATA_BITS-1:0] rx_byte;
  logic                 rx_ferr;
  logic                 unused_rx;

  tbuart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clock   (clock),
    .resetb  (resetb),
    .ser_rx  (ser_rx),
    .rx_done (rx_done),
    .rx_byte (rx_byte),
    .rx_ferr (rx_ferr)
  );

  // Byte value and framing errors are reported by the simulation monitor,
  // which watches these nets directly; only rx_done drives logic here.
  assign unused_rx = ^{rx_byte, rx_ferr};

  // ---------------- transmitter ----------------
  uart_state_e          tx_state_q, tx_state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 ser_tx_q, ser_tx_d;
  logic                 busy_q, busy_d;
  logic                 start_q;            // registered copy of tx_start
  logic                 armed_q, armed_d;   // tx_start seen low since reset
  logic                 clr_q, clr_d;
  logic                 start_edge, frame_start;

  // A level already high when reset releases must not count as an edge, so
  // the detector only arms once tx_start has been seen low.
  assign armed_d     = armed_q | ~tx_start;
  assign start_edge  = tx_start & ~start_q & armed_q;
  assign frame_start = (tx_state_q == ST_IDLE) & start_edge;

  always_comb begin
    tx_state_d = tx_state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    ser_tx_d   = ser_tx_q;
    busy_d     = busy_q;

    case (tx_state_q)
      ST_IDLE: begin
        ser_tx_d = 1'b1;
        busy_d   = 1'b0;
        cnt_d    = '0;
        idx_d    = '0;
        if (start_edge) begin
          shreg_d    = tx_data;
          ser_tx_d   = 1'b0;
          busy_d     = 1'b1;
          tx_state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d      = '0;
          ser_tx_d   = shreg_q[0];
          tx_state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d      = '0;
            ser_tx_d   = 1'b1;
            tx_state_d = ST_STOP;
          end else begin
            idx_d    = idx_q + IW'(1);
            ser_tx_d = shreg_q[idx_q + IW'(1)];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d      = '0;
          busy_d     = 1'b0;
          tx_state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        tx_state_d = ST_IDLE;
        cnt_d      = '0;
        idx_d      = '0;
        ser_tx_d   = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // A receive completion on the same clock as a TX start leaves the request set.
  always_comb begin
    clr_d = clr_q;
    if (rx_done)          clr_d = 1'b1;
    else if (frame_start) clr_d = 1'b0;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      tx_state_q <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      ser_tx_q   <= 1'b1;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      armed_q    <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      ser_tx_q   <= ser_tx_d;
      busy_q     <= busy_d;
      start_q    <= tx_start;
      armed_q    <= armed_d;
      clr_q      <= clr_d;
    end
  end

  assign ser_tx       = ser_tx_q;
  assign tx_busy      = busy_q;
  assign tx_clear_req = clr_q;

endmodule

// File: tb/tb_tbuart.sv
// tb_tbuart: directed, scoreboard-based bench for tbuart with a short bit time.
`timescale 1ns/1ps
module tb_tbuart;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       resetb;
  logic       ser_rx;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ser_tx;
  logic       tx_busy;
  logic       tx_clear_req;

  tbuart #(.CLKS_PER_BIT(CPB)) dut (
    .clock        (clock),
    .resetb       (resetb),
    .ser_rx       (ser_rx),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .ser_tx       (ser_tx),
    .tx_busy      (tx_busy),
    .tx_clear_req (tx_clear_req)
  );

  always #12.5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_done = 0;
  int n_ferr = 0;
  int done_cyc = 0;
  int tx_rise_cyc = 0;
  int rx_t0 = 0;

  logic [9:0] sb_tx[$];
  logic [7:0] sb_rx[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] make_frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Receive-side monitor: pops the expected byte whenever the receiver completes.
  always @(negedge clock) begin
    if (resetb && dut.rx_done) begin
      n_done++;
      done_cyc = cyc;
      $display("tbuart rx: '%c' (0x%02h)", dut.rx_byte, dut.rx_byte);
      check("rx_expected_pending", 32'(sb_rx.size() != 0), 1);
      if (sb_rx.size() != 0) check("rx_byte", dut.rx_byte, sb_rx.pop_front());
    end
    if (resetb && dut.rx_ferr) begin
      n_ferr++;
      $display("tbuart rx: framing error, byte discarded");
    end
  end

  // Call right after raising tx_start; checks latency, bit values, busy time.
  task automatic tx_expect(input string tag);
    logic [9:0] exp;
    logic [9:0] got;
    int n;
    int t0;
    exp = sb_tx.pop_front();
    got = '0;
    n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (!tx_busy && n < 2);
    check({tag, "_busy_rise"}, tx_busy, 1);
    if (tx_busy) begin
      t0 = cyc;
      tx_rise_cyc = cyc;
      repeat (CPB/2) @(posedge clock);
      #1 got[0] = ser_tx;
      for (int i = 1; i < 10; i++) begin
        repeat (CPB) @(posedge clock);
        #1 got[i] = ser_tx;
      end
      check({tag, "_frame"}, got, exp);
      n = 0;
      while (tx_busy && n < 2*CPB) begin
        @(posedge clock); #1; n++;
      end
      check({tag, "_busy_len"},
            32'(((cyc - t0) >= 10*CPB - 1) && ((cyc - t0) <= 10*CPB + 1)), 1);
    end
  endtask

  task automatic tx_send(input logic [7:0] d, input string tag);
    @(negedge clock);
    tx_data  = d;
    tx_start = 1'b1;
    sb_tx.push_back(make_frame(d));
    tx_expect(tag);
  endtask

  // Call at a negedge; drives one frame onto ser_rx.
  task automatic rx_send(input logic [7:0] b, input logic stop);
    ser_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    ser_rx = stop;
    repeat (CPB) @(negedge clock);
    ser_rx = 1'b1;
  endtask

  task automatic idle_window(input int n, input string tag);
    logic bad;
    bad = 1'b0;
    repeat (n) begin
      @(negedge clock);
      if (tx_busy || !ser_tx) bad = 1'b1;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    #(25 * 40000);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int done0, ferr0, d, d_cal, n;

    resetb = 1'b0; ser_rx = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clock);
    check("reset_ser_tx", ser_tx, 1);
    check("reset_tx_busy", tx_busy, 0);
    check("reset_clear_req", tx_clear_req, 0);
    resetb = 1'b1;
    repeat (3) @(negedge clock);

    // Basic frame, then tx_start held high must not retrigger.
    tx_send(8'h3D, "tx_3d");
    idle_window(3*CPB, "no_retrigger_held_high");
    @(negedge clock) tx_start = 1'b0;
    repeat (2) @(negedge clock);

    // Second frame; data and tx_start toggled mid-frame must be ignored.
    tx_data = 8'h0F; tx_start = 1'b1;
    sb_tx.push_back(make_frame(8'h0F));
    fork
      tx_expect("tx_0f");
      begin
        repeat (3*CPB) @(negedge clock);
        tx_data = 8'hFF; tx_start = 1'b0;
        @(negedge clock) tx_start = 1'b1;
      end
    join
    idle_window(2*CPB, "busy_edge_ignored");
    @(negedge clock) tx_start = 1'b0;
    check("clear_req_before_rx", tx_clear_req, 0);

    // Valid received byte sets tx_clear_req near the stop-bit centre.
    @(negedge clock);
    rx_t0 = cyc; done0 = n_done;
    sb_rx.push_back(8'h0F);
    rx_send(8'h0F, 1'b1);
    check("rx_0f_done", n_done, done0 + 1);
    check("clear_req_set", tx_clear_req, 1);
    d = done_cyc - rx_t0;
    check("rx_done_at_stop_centre",
          32'((d >= 9*CPB + CPB/2) && (d <= 9*CPB + CPB/2 + 4)), 1);
    repeat (3*CPB) @(negedge clock);
    check("clear_req_hold", tx_clear_req, 1);
    tx_send(8'h55, "tx_55");
    check("clear_req_cleared_by_tx", tx_clear_req, 0);
    @(negedge clock) tx_start = 1'b0;

    // Framing error, then a short glitch, then recovery.
    @(negedge clock);
    done0 = n_done; ferr0 = n_ferr;
    rx_send(8'h41, 1'b0);
    repeat (2*CPB) @(negedge clock);
    check("ferr_reported", n_ferr, ferr0 + 1);
    check("ferr_no_byte", n_done, done0);
    check("ferr_clear_req", tx_clear_req, 0);
    ser_rx = 1'b0;
    repeat ((3*CPB + 5) / 10) @(negedge clock);
    ser_rx = 1'b1;
    repeat (2*CPB) @(negedge clock);
    check("glitch_no_byte", n_done, done0);
    check("glitch_no_ferr", n_ferr, ferr0 + 1);
    check("glitch_clear_req", tx_clear_req, 0);
    sb_rx.push_back(8'h41);
    rx_send(8'h41, 1'b1);
    repeat (2) @(negedge clock);
    check("recover_done", n_done, done0 + 1);
    check("recover_clear_req", tx_clear_req, 1);

    // Reset in the middle of frame bit 4.
    @(negedge clock);
    tx_data = 8'hA5; tx_start = 1'b1;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!tx_busy && n < 2);
    check("abort_busy_rise", tx_busy, 1);
    repeat (4*CPB + CPB/2) @(posedge clock);
    #5 check("abort_pre_bit4", ser_tx, 0);
    resetb = 1'b0;
    #1;
    check("abort_ser_tx", ser_tx, 1);
    check("abort_tx_busy", tx_busy, 0);
    check("abort_clear_req", tx_clear_req, 0);
    repeat (2) @(negedge clock);
    resetb = 1'b1;
    idle_window(12*CPB, "no_start_after_reset");
    @(negedge clock) tx_start = 1'b0;
    repeat (2) @(negedge clock);

    // Full duplex: receive 0x0F while transmitting 0x3D.
    rx_t0 = cyc; done0 = n_done;
    sb_rx.push_back(8'h0F);
    tx_data = 8'h3D; tx_start = 1'b1;
    sb_tx.push_back(make_frame(8'h3D));
    fork
      tx_expect("dup_tx");
      rx_send(8'h0F, 1'b1);
    join
    check("dup_rx_done", n_done, done0 + 1);
    check("dup_clear_req", tx_clear_req, 1);
    d_cal = done_cyc - rx_t0;
    @(negedge clock) tx_start = 1'b0;
    repeat (CPB) @(negedge clock);

    // RX completion on the same clock as a TX start: set wins.
    rx_t0 = cyc; done0 = n_done;
    sb_rx.push_back(8'h0F);
    fork
      rx_send(8'h0F, 1'b1);
      begin
        n = 0;
        while (cyc != rx_t0 + d_cal && n < 20*CPB) begin
          @(negedge clock); n++;
        end
        tx_data = 8'h66; tx_start = 1'b1;
        sb_tx.push_back(make_frame(8'h66));
        tx_expect("coinc_tx");
      end
    join
    check("coinc_rx_done", n_done, done0 + 1);
    check("coinc_aligned", tx_rise_cyc, done_cyc + 1);
    check("coinc_set_wins", tx_clear_req, 1);
    @(negedge clock) tx_start = 1'b0;

    repeat (4) @(negedge clock);
    check("sb_tx_empty", sb_tx.size(), 0);
    check("sb_rx_empty", sb_rx.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tbuart.md
TBUART -- requirements
Module: tbuart

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: port "clock" (clock) and port "resetb" (reset).
REQ-002 Parameter CLKS_PER_BIT, default 347 (115200 baud at 40 MHz), SHALL set the number of clock cycles per serial bit for both RX and TX.
REQ-003 Ports SHALL be:
- clock  input  1  system clock, 25 ns period
- resetb  input  1  asynchronous active-low reset
- ser_rx  input  1  serial data from the chip UART TX (idle high)
- tx_start  input  1  level request to send tx_data; a rising edge starts one frame
- tx_data  input  8  byte to transmit, sampled when a frame starts
- ser_tx  output  1  serial data to the chip UART RX (idle high)
- tx_busy  output  1  high while a TX frame is in progress
- tx_clear_req  output  1  high once a byte has been received on ser_rx since the last TX start; tells the bench it may send the next byte

Function
REQ-004 The frame format SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1), each CLKS_PER_BIT cycles long.
REQ-005 TX states SHALL be IDLE, START, DATA, STOP; any other encoding SHALL return to IDLE.
REQ-006 In IDLE, a rising edge of tx_start, detected against a registered copy, SHALL latch tx_data, drive START, and set tx_busy high no later than the second clock edge after tx_start rises.
REQ-007 ser_tx SHALL hold each bit for exactly CLKS_PER_BIT cycles; DATA SHALL use a 3-bit index wrapping from 7 to STOP.
REQ-008 At the end of STOP, the TX path SHALL clear tx_busy and return to IDLE; total busy time SHALL be 10*CLKS_PER_BIT +/- 1 cycle.
REQ-009 tx_start held high after a frame SHALL NOT start another frame; a new frame requires tx_start to go low and then high again.
REQ-010 A tx_start rising edge while tx_busy is high SHALL be ignored, and tx_data changes during a frame SHALL NOT affect it.
REQ-011 RX states SHALL be IDLE, START, DATA, STOP. A falling edge on a 2-flop-synchronized ser_rx in IDLE SHALL enter START.
REQ-012 The RX path SHALL re-check the start bit at CLKS_PER_BIT/2; if it is high, RX SHALL return to IDLE as a glitch.
REQ-013 The RX path SHALL then sample each data bit and the stop bit at bit centres, every CLKS_PER_BIT cycles.
REQ-014 If the stop bit is 1, the RX path SHALL set tx_clear_req and, in simulation, print the received byte as a character and in hex.
REQ-015 If the stop bit is 0 (framing error), the RX path SHALL discard the byte, print a framing-error message, leave tx_clear_req unchanged, and return to IDLE once ser_rx is high.
REQ-016 tx_clear_req SHALL clear on the clock a TX frame starts; if an RX completion and a TX start occur on the same clock, the set SHALL win.
REQ-017 RX and TX SHALL operate fully independently, full duplex.

Reset
REQ-018 While resetb is low: ser_tx=1, tx_busy=0, tx_clear_req=0, both FSMs in IDLE, all counters and shift registers 0, and the registered tx_start copy 0.
REQ-019 Reset asserted mid-frame SHALL abort the frame immediately and drive ser_tx high; after release, an already-high tx_start SHALL NOT start a frame.

Structure
REQ-020 A shared package SHALL hold the state enumeration (IDLE, START, DATA, STOP), the frame constants (DATA_BITS=8, STOP_BITS=1), and the default CLKS_PER_BIT.
REQ-021 The receiver SHALL be one sub-module, tbuart_rx, with outputs rx_done, rx_byte, and rx_ferr; the TX path and tx_clear_req logic SHALL stay in the top module.

Verification
REQ-022 tx_start rises with tx_data=61 (0x3D) -> tx_busy high within 2 clocks; ser_tx bits 0,1,0,1,1,1,1,0,0,1; tx_busy falls after 10*CLKS_PER_BIT cycles.
REQ-023 tx_start stays high after the 0x3D frame -> no second frame; tx_start low then high with tx_data=15 -> frame 0,1,1,1,1,0,0,0,0,1.
REQ-024 Drive ser_rx with a valid 0x0F frame -> tx_clear_req rises at the stop-bit centre and stays high until the next TX start.
REQ-025 Drive ser_rx with 0x41 and stop bit 0 -> tx_clear_req stays 0 and a framing error is reported; a 0.3-bit low glitch on ser_rx -> no byte reported.
REQ-026 Assert resetb at bit 4 of a TX frame -> ser_tx=1 and tx_busy=0 immediately; after release with tx_start still high -> ser_tx stays idle.
REQ-027 Receive 0x0F while transmitting 0x3D -> both complete correctly, and tx_clear_req set-wins if the RX completion coincides with a TX start.
